// File: rtl/fp_share_arb_pkg.sv
// Shared types for the fp_unit port arbiter: fp_unit request/response
// records, arbiter state encoding and the registered response record.
package fp_share_arb_pkg;

    // Widest requester tag the response record can carry.
    localparam int unsigned FP_ARB_IDW_MAX = 16;

    typedef enum logic [3:0] {
        FP_OP_ADD  = 4'd0,
        FP_OP_SUB  = 4'd1,
        FP_OP_MUL  = 4'd2,
        FP_OP_DIV  = 4'd3,
        FP_OP_SQRT = 4'd4,
        FP_OP_FMA  = 4'd5,
        FP_OP_CMP  = 4'd6,
        FP_OP_CVT  = 4'd7
    } fp_op_type;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] data3;
        fp_op_type   op;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic        enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;   // NV,DZ,OF,UF,NX
        logic        ready;
    } fp_exe_out_type;

    typedef enum logic [1:0] {
        FP_ARB_IDLE  = 2'd0,
        FP_ARB_ISSUE = 2'd1,
        FP_ARB_WAIT  = 2'd2
    } fp_arb_state_type;

    typedef struct packed {
        logic [31:0]               result;
        logic [4:0]                flags;
        logic [FP_ARB_IDW_MAX-1:0] id;
    } fp_arb_rsp_type;

    // Requesters' enable bits carry no meaning; the arbiter owns the pulse.
    function automatic fp_exe_in_type fp_arb_strip_enable(input fp_exe_in_type op);
        fp_exe_in_type r;
        r        = op;
        r.enable = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/fp_share_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its index.
import fp_share_arb_pkg::*;

module fp_rr_pick #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IDXW = $clog2(NREQ);

    logic [IDXW-1:0] cand;
    logic            found;

    // Scan from ptr upward; the first pending request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDXW'((32'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fp_share_arb.sv
// Shares one fp_unit port between NREQ requesters. Accepts one operation
// at a time in IDLE, pulses enable for one cycle in ISSUE, then waits in
// WAIT for fp_unit ready and returns the result to the issuing requester.
import fp_share_arb_pkg::*;

module fp_share_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  fp_exe_in_type            req_op [NREQ],
    input  logic [NREQ-1:0][IDW-1:0] req_id,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [31:0]              rsp_result,
    output logic [4:0]               rsp_flags,
    output logic [IDW-1:0]           rsp_id,
    output fp_exe_in_type            fp_exe_i,
    input  fp_exe_out_type           fp_exe_o,
    output logic                     busy
);

    localparam int unsigned IDXW = $clog2(NREQ);

    fp_arb_state_type state_q, state_d;
    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    fp_exe_in_type    op_q, op_d;
    logic [IDW-1:0]   id_q, id_d;
    fp_arb_rsp_type   rsp_q, rsp_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]  pick_grant;
    logic [IDXW-1:0]  pick_idx;

    fp_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // State register, operation latches and registered response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= FP_ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state, accept and response capture; fp_unit ready is only
    // honoured in WAIT since its idle level is stale.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_d       = rsp_q;
        rsp_valid_d = '0;
        req_ready   = '0;
        unique case (state_q)
            FP_ARB_IDLE: begin
                if (reset && (|req_valid)) begin
                    req_ready = pick_grant;
                    owner_d   = pick_idx;
                    op_d      = fp_arb_strip_enable(req_op[pick_idx]);
                    id_d      = req_id[pick_idx];
                    state_d   = FP_ARB_ISSUE;
                end
            end
            FP_ARB_ISSUE: begin
                state_d = FP_ARB_WAIT;
            end
            FP_ARB_WAIT: begin
                if (fp_exe_o.ready) begin
                    rsp_d.result         = fp_exe_o.result;
                    rsp_d.flags          = fp_exe_o.flags;
                    rsp_d.id             = FP_ARB_IDW_MAX'(id_q);
                    rsp_valid_d[owner_q] = 1'b1;
                    rr_ptr_d             = IDXW'((32'(owner_q) + 32'd1) % NREQ);
                    state_d              = FP_ARB_IDLE;
                end
            end
            default: begin
                state_d = FP_ARB_IDLE;
            end
        endcase
    end

    // Latched op goes out every cycle; enable only during ISSUE.
    always_comb begin
        fp_exe_i        = op_q;
        fp_exe_i.enable = (state_q == FP_ARB_ISSUE);
    end

    assign busy       = (state_q != FP_ARB_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_q.result;
    assign rsp_flags  = rsp_q.flags;
    assign rsp_id     = IDW'(rsp_q.id);

endmodule
